// File: rtl/ro_freq_meter.sv
// ro_freq_meter
//   Measures the frequency of one free-running ring-oscillator output as the
//   number of rising edges seen in a fixed gate window of WINDOW_CYCLES
//   clk_50MHz cycles. Results feed the clock-selection/power-mode controller.
//
//   Optional build macro FREQ_AVG_EN: when defined, freq_count publishes the
//   rounded mean of the current and previous window counts. The first window
//   after reset or after leaving IDLE publishes the current count alone.
//
// Ports
//   clk_50MHz   in   system clock, rising edge
//   rst         in   asynchronous active-low reset
//   enable      in   measurement run request (level)
//   ro_in       in   raw oscillator output, asynchronous to clk_50MHz
//   fro_min     in   minimum acceptable count, sampled at each window end
//   freq_count  out  count from the last completed window
//   freq_valid  out  one-cycle strobe, freq_count updated this cycle
//   below_min   out  current window count < fro_min (1 until first result)
//   saturated   out  last window's edge count exceeded 2^CNT_W-1
//   busy        out  high in ARM and RUN
module ro_freq_meter #(
  parameter int WINDOW_CYCLES = 100,
  parameter int CNT_W         = 8,
  parameter int SYNC_STAGES   = 2
) (
  input  logic             clk_50MHz,
  input  logic             rst,
  input  logic             enable,
  input  logic             ro_in,
  input  logic [CNT_W-1:0] fro_min,
  output logic [CNT_W-1:0] freq_count,
  output logic             freq_valid,
  output logic             below_min,
  output logic             saturated,
  output logic             busy
);

  localparam int WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int ARM_W = $clog2(SYNC_STAGES + 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(SYNC_STAGES);
  localparam logic [CNT_W:0]   EDGE_MAX = '1;

  typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

  // Clamp the wide edge count into the published width.
  function automatic logic [CNT_W-1:0] clamp_cnt(input logic [CNT_W:0] val);
    return val[CNT_W] ? {CNT_W{1'b1}} : val[CNT_W-1:0];
  endfunction

  // Saturating increment of the edge counter.
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W:0] val, input logic inc);
    return (inc && (val != EDGE_MAX)) ? val + {{CNT_W{1'b0}}, 1'b1} : val;
  endfunction

`ifdef FREQ_AVG_EN
  // Rounded mean, computed one bit wider so the +1 cannot overflow.
  function automatic logic [CNT_W-1:0] round_mean(input logic [CNT_W-1:0] a,
                                                  input logic [CNT_W-1:0] b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b} + {{CNT_W{1'b0}}, 1'b1};
    return sum[CNT_W:1];
  endfunction
`endif

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   hist_p1;
  logic                   edge_det;
  logic [ARM_W-1:0]       arm_cnt;
  logic [WIN_W-1:0]       win_cnt;
  logic [CNT_W:0]         edge_cnt;
  logic [CNT_W:0]         edge_sum;
  logic [CNT_W-1:0]       cur_cnt;
  logic [CNT_W-1:0]       pub_cnt;
  logic                   win_end;
  logic                   cnt_keep;

  // Synchronizer stages, then one history flop for rising-edge detection
  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      sync_p0 <= '0;
      hist_p1 <= 1'b0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], ro_in};
      hist_p1 <= sync_p0[SYNC_STAGES-1];
    end
  end

  assign edge_det = sync_p0[SYNC_STAGES-1] & ~hist_p1;

  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    win_end = 1'b0;
    case (state_q)
      IDLE: if (enable) state_d = ARM;
      ARM: begin
        if (!enable)                  state_d = IDLE;
        else if (arm_cnt == ARM_LAST) state_d = RUN;
      end
      RUN: begin
        // A window that ends while enable is low is still published.
        win_end = (win_cnt == WIN_LAST);
        if (!enable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // An edge landing on the window's last cycle belongs to that window.
  assign edge_sum = sat_inc(edge_cnt, edge_det);
  assign cur_cnt  = clamp_cnt(edge_sum);
  // Counters run only while staying in RUN inside a window; otherwise they
  // restart at 0, which also discards a partial window on abort.
  assign cnt_keep = (state_q == RUN) && (state_d == RUN) && !win_end;
  assign busy     = (state_q != IDLE);

  // Window counters
  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      arm_cnt  <= '0;
      win_cnt  <= '0;
      edge_cnt <= '0;
    end else begin
      arm_cnt  <= ((state_q == ARM) && (state_d == ARM)) ? arm_cnt + ARM_W'(1) : '0;
      win_cnt  <= cnt_keep ? win_cnt + WIN_W'(1) : '0;
      edge_cnt <= cnt_keep ? edge_sum : '0;
    end
  end

`ifdef FREQ_AVG_EN
  logic [CNT_W-1:0] prev_cnt;
  logic             have_prev;

  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      prev_cnt  <= '0;
      have_prev <= 1'b0;
    end else if (state_q == IDLE) begin
      have_prev <= 1'b0;
    end else if (win_end) begin
      prev_cnt  <= cur_cnt;
      have_prev <= 1'b1;
    end
  end

  assign pub_cnt = have_prev ? round_mean(prev_cnt, cur_cnt) : cur_cnt;
`else
  assign pub_cnt = cur_cnt;
`endif

  // Published results, held between strobes
  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      freq_count <= '0;
      freq_valid <= 1'b0;
      below_min  <= 1'b1;
      saturated  <= 1'b0;
    end else begin
      freq_valid <= win_end;
      if (win_end) begin
        freq_count <= pub_cnt;
        saturated  <= edge_sum[CNT_W];
        below_min  <= (cur_cnt < fro_min);
      end
    end
  end

endmodule
